// File: rtl/dr_alm_pkg.sv
// Shared DR-ALM definitions: LC-word geometry, field offsets and pack/unpack
// helpers used by both the log encoder and the multiplication unit.
package dr_alm_pkg;

  localparam int DEF_A_BW    = 32;
  localparam int DEF_B_BW    = 32;
  localparam int DEF_MULT_DW = 5;

  localparam int MAX_BW  = (DEF_A_BW > DEF_B_BW) ? DEF_A_BW : DEF_B_BW;
  localparam int BW_LG   = $clog2(MAX_BW);
  localparam int TRUNC_W = DEF_MULT_DW + 1;
  localparam int LC_W    = BW_LG + TRUNC_W + 1;

  // Field offsets inside an LC word {k, mantissa, tag}.
  localparam int LC_TAG_POS  = 0;
  localparam int LC_MANT_LSB = 1;
  localparam int LC_K_LSB    = TRUNC_W + 1;

  typedef logic [LC_W-1:0] lc_word_t;

  typedef struct packed {
    logic [BW_LG-1:0]   k;
    logic [TRUNC_W-1:0] mant;
    logic               tag;
  } lc_fields_t;

  function automatic lc_word_t lc_pack(input logic [BW_LG-1:0] k,
                                       input logic [TRUNC_W-1:0] mant);
    return {k, mant, 1'b1};
  endfunction

  function automatic lc_fields_t lc_unpack(input lc_word_t w);
    return lc_fields_t'(w);
  endfunction

endpackage

// File: rtl/dr_alm_lod_pe.sv
// Combinational leading-one detector and priority encoder.
// k is the index of the most-significant set bit; zero flags an all-zero input.
module dr_alm_lod_pe #(
  parameter int BW = 32,
  parameter int KW = $clog2(BW)
) (
  input  logic [BW-1:0] x,
  output logic [KW-1:0] k,
  output logic          zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves k unassigned (no latch).
    k = '0;
    for (int i = 0; i < BW; i++) begin
      if (x[i]) k = KW'(i);
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/dr_alm_log_encoder.sv
// DR-ALM log encoder: operands -> packed log-domain words {k, trunc, 1'b1}.
// Two-stage elastic valid/ready pipeline (stage 1: LOD/PE, stage 2: truncate+pack).
// Optional macro DR_ALM_SIGNED_EN: two's-complement operands with product sign.
module dr_alm_log_encoder
  import dr_alm_pkg::*;
#(
  parameter int A_BW    = DEF_A_BW,
  parameter int B_BW    = DEF_B_BW,
  parameter int MULT_DW = DEF_MULT_DW,
  localparam int MX_BW  = (A_BW > B_BW) ? A_BW : B_BW,
  localparam int K_W    = $clog2(MX_BW),
  localparam int T_W    = MULT_DW + 1,
  localparam int W      = K_W + T_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [A_BW-1:0] A,
  input  logic [B_BW-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    LC_OP_A_wire,
  output logic [W-1:0]    LC_OP_B_wire,
  output logic            lc_zero,
  output logic            lc_sign
);

  // Normalise so the leading one sits at the MSB, then keep the T_W bits
  // directly below it; short operands get zero-padded LSBs by the shift.
  function automatic logic [T_W-1:0] trunc_of(input logic [MX_BW-1:0] mag,
                                               input logic [K_W-1:0]   k);
    return T_W'((mag << (K_W'(MX_BW - 1) - k)) >> (MX_BW - 1 - T_W));
  endfunction

  logic [MX_BW-1:0] mag_a, mag_b;
  logic [K_W-1:0]   k_a, k_b;
  logic             zero_a, zero_b;
  logic             sign_d;

`ifdef DR_ALM_SIGNED_EN
  // Magnitude of a two's-complement value; the most-negative value maps to 2^(BW-1).
  assign mag_a  = MX_BW'(A[A_BW-1] ? (~A + A_BW'(1)) : A);
  assign mag_b  = MX_BW'(B[B_BW-1] ? (~B + B_BW'(1)) : B);
  assign sign_d = A[A_BW-1] ^ B[B_BW-1];
`else
  assign mag_a  = MX_BW'(A);
  assign mag_b  = MX_BW'(B);
  assign sign_d = 1'b0;
`endif

  dr_alm_lod_pe #(.BW(MX_BW), .KW(K_W)) u_lod_a (.x(mag_a), .k(k_a), .zero(zero_a));
  dr_alm_lod_pe #(.BW(MX_BW), .KW(K_W)) u_lod_b (.x(mag_b), .k(k_b), .zero(zero_b));

  logic             s1_v;
  logic [MX_BW-1:0] s1_mag_a, s1_mag_b;
  logic [K_W-1:0]   s1_k_a, s1_k_b;
  logic             s1_zero_a, s1_zero_b, s1_sign;
  logic             s2_v, s2_load;

  assign s2_load   = ~s2_v | out_ready;
  assign in_ready  = ~s1_v | s2_load;
  assign out_valid = s2_v;

  // Stage 1: capture magnitude, leading-one index and zero flag on accept.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (rst) begin
      s1_v      <= 1'b0;
      // NOTE: datapath flops are reset too, so nothing stale survives a reset.
      s1_mag_a  <= '0;
      s1_mag_b  <= '0;
      s1_k_a    <= '0;
      s1_k_b    <= '0;
      s1_zero_a <= 1'b0;
      s1_zero_b <= 1'b0;
      s1_sign   <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_mag_a  <= mag_a;
        s1_mag_b  <= mag_b;
        s1_k_a    <= k_a;
        s1_k_b    <= k_b;
        s1_zero_a <= zero_a;
        s1_zero_b <= zero_b;
        s1_sign   <= sign_d;
      end
    end
  end

  // Stage 2: build LC words; held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v         <= 1'b0;
      LC_OP_A_wire <= '0;
      LC_OP_B_wire <= '0;
      lc_zero      <= 1'b0;
      lc_sign      <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        LC_OP_A_wire <= s1_zero_a ? '0 : {s1_k_a, trunc_of(s1_mag_a, s1_k_a), 1'b1};
        LC_OP_B_wire <= s1_zero_b ? '0 : {s1_k_b, trunc_of(s1_mag_b, s1_k_b), 1'b1};
        lc_zero      <= s1_zero_a | s1_zero_b;
        lc_sign      <= s1_sign & ~(s1_zero_a | s1_zero_b);
      end
    end
  end

endmodule

// File: tb/tb_dr_alm_log_encoder.sv
// Directed self-checking bench for dr_alm_log_encoder (32/32/5 -> 12-bit LC).
module tb_dr_alm_log_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] lc_a, lc_b;
  logic        lc_zero, lc_sign;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  dr_alm_log_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .LC_OP_A_wire (lc_a),
    .LC_OP_B_wire (lc_b),
    .lc_zero      (lc_zero),
    .lc_sign      (lc_sign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction: accept, confirm 2-cycle latency, check result.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [11:0] ea, input logic [11:0] eb,
                        input logic ez, input logic es);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lc_a"}, 32'(lc_a), 32'(ea));
    check({tag, "_lc_b"}, 32'(lc_b), 32'(eb));
    check({tag, "_zero"}, 32'(lc_zero), 32'(ez));
    check({tag, "_sign"}, 32'(lc_sign), 32'(es));
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [11:0] ea [8];
  logic [11:0] eb [8];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          idx, rx, inflight_at_drop;
    logic        acc, was_stalled;
    logic [11:0] held_a, held_b;

    // Item i: A = 1<<4i (k=4i, trunc 0), B = i+1 (small, zero-padded trunc).
    for (int i = 0; i < 8; i++) begin
      sa[i] = 32'h1 << (4 * i);
      sb[i] = 32'(i + 1);
    end
    ea = '{12'h001, 12'h201, 12'h401, 12'h601, 12'h801, 12'hA01, 12'hC01, 12'hE01};
    eb = '{12'h001, 12'h081, 12'h0C1, 12'h101, 12'h121, 12'h141, 12'h161, 12'h181};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_lc_a", 32'(lc_a), 32'd0);
    check("rst_lc_b", 32'(lc_b), 32'd0);
    check("rst_zero", 32'(lc_zero), 32'd0);
    check("rst_sign", 32'(lc_sign), 32'd0);

    single("t1", 32'h1, 32'h8000_0000, 12'h001, 12'hF81, 1'b0, 1'b0);
    single("t2", 32'hB4, 32'h5, 12'h3B5, 12'h121, 1'b0, 1'b0);
    single("t3", 32'h0, 32'h7, 12'h000, 12'h161, 1'b1, 1'b0);
`ifdef DR_ALM_SIGNED_EN
    single("t6a", 32'hFFFF_FFFB, 32'h3, 12'h121, 12'h0C1, 1'b0, 1'b1);
    single("t6b", 32'h8000_0000, 32'h1, 12'hF81, 12'h001, 1'b0, 1'b1);
    single("t6z", 32'hFFFF_FFFB, 32'h0, 12'h121, 12'h000, 1'b1, 1'b0);
`else
    single("t6u", 32'hFFFF_FFFB, 32'h3, 12'hFFF, 12'h0C1, 1'b0, 1'b0);
`endif

    // Back-to-back stream with downstream stalled in cycles 3..6.
    idx = 0; rx = 0; inflight_at_drop = -1; was_stalled = 1'b0;
    held_a = '0; held_b = '0;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 8) begin
        in_valid = 1'b1; A = sa[idx]; B = sb[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (was_stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_lc_a", 32'(lc_a), 32'(held_a));
        check("stall_lc_b", 32'(lc_b), 32'(held_b));
      end
      if (!in_ready && inflight_at_drop < 0) inflight_at_drop = idx - rx;
      if (out_valid && out_ready) begin
        if (rx < 8) begin
          check("stream_lc_a", 32'(lc_a), 32'(ea[rx]));
          check("stream_lc_b", 32'(lc_b), 32'(eb[rx]));
        end else begin
          check("stream_extra", 32'(rx), 32'd7);
        end
        rx++;
        was_stalled = 1'b0;
      end else if (out_valid) begin
        held_a = lc_a; held_b = lc_b;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_accepted", 32'(idx), 32'd8);
    check("stream_delivered", 32'(rx), 32'd8);
    check("stream_inflight_at_drop", 32'(inflight_at_drop), 32'd2);

    // Fill both stages under backpressure, then reset.
    out_ready = 1'b0;
    in_valid = 1'b1; A = 32'hB4; B = 32'h5;
    @(negedge clk);
    A = 32'h7; B = 32'h7;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_lc_a", 32'(lc_a), 32'h3B5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_lc_a", 32'(lc_a), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
